// File: rtl/sram_ctrl_32b.sv
// 32-bit load/store responder for a 256Kx16 async SRAM: each word is split into
// a low and a high half-word access, and completion is signalled with a one-cycle ack.
module sram_ctrl_32b #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_wren,
   input  logic [18:0] i_addr,
   input  logic [3:0]  i_bmask,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ack,
   output logic        o_busy,
   output logic [17:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_UB_N
);

   localparam int unsigned WCNT_W = 3;
   localparam int unsigned WORD_W = 17;
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_ACK  = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
   logic                w_accept, w_phase_end, w_cap_lo, w_cap_hi;

   logic [WORD_W-1:0]   r_word, w_word_nxt;
   logic                r_wren, w_wren_nxt;
   logic [3:0]          r_bmask, w_bmask_nxt;
   logic [31:0]         r_wdata, w_wdata_nxt;
   logic [31:0]         r_rdata;
   logic                r_ack, r_busy;

   logic [17:0]         r_sram_addr, w_sram_addr;
   logic                r_ce_n, r_we_n, r_oe_n, r_lb_n, r_ub_n;
   logic                w_ce_n, w_we_n, w_oe_n, w_lb_n, w_ub_n;
   logic                r_dq_oe, w_dq_oe;
   logic [15:0]         r_dq_out, w_dq_out;
   logic                w_is_hi;
   logic [1:0]          w_lane;

   logic                w_unused_addr_lsb;
   assign w_unused_addr_lsb = ^i_addr[1:0];

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   // Next state, request latching and next-cycle pin decode
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_accept    = 1'b0;
      w_cap_lo    = 1'b0;
      w_cap_hi    = 1'b0;
      w_phase_end = (r_wcnt == WCNT_MAX);
      w_ce_n      = 1'b1;
      w_we_n      = 1'b1;
      w_oe_n      = 1'b1;
      w_lb_n      = 1'b1;
      w_ub_n      = 1'b1;
      w_dq_oe     = 1'b0;
      w_dq_out    = r_dq_out;
      w_sram_addr = r_sram_addr;

      case (r_state)
         ST_IDLE: begin
            if (i_req) begin
               w_accept   = 1'b1;
               w_wcnt_nxt = '0;
               if (!i_wren || (|i_bmask[1:0])) w_state_nxt = ST_LO;
               else if (|i_bmask[3:2])         w_state_nxt = ST_HI;
               else                            w_state_nxt = ST_ACK;
            end
         end
         ST_LO: begin
            if (w_phase_end) begin
               w_wcnt_nxt  = '0;
               w_cap_lo    = !r_wren;
               w_state_nxt = (!r_wren || (|r_bmask[3:2])) ? ST_HI : ST_ACK;
            end else begin
               w_wcnt_nxt = r_wcnt + WCNT_W'(1);
            end
         end
         ST_HI: begin
            if (w_phase_end) begin
               w_wcnt_nxt  = '0;
               w_cap_hi    = !r_wren;
               w_state_nxt = ST_ACK;
            end else begin
               w_wcnt_nxt = r_wcnt + WCNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_word_nxt  = w_accept ? i_addr[18:2] : r_word;
      w_wren_nxt  = w_accept ? i_wren       : r_wren;
      w_bmask_nxt = w_accept ? i_bmask      : r_bmask;
      w_wdata_nxt = w_accept ? i_wdata      : r_wdata;

      // Pins are registered from the next state so they never see i_* combinationally
      w_is_hi = (w_state_nxt == ST_HI);
      w_lane  = w_is_hi ? w_bmask_nxt[3:2] : w_bmask_nxt[1:0];
      if ((w_state_nxt == ST_LO) || w_is_hi) begin
         w_ce_n      = 1'b0;
         w_sram_addr = {w_word_nxt, w_is_hi};
         if (w_wren_nxt) begin
            w_we_n   = 1'b0;
            w_lb_n   = ~w_lane[0];
            w_ub_n   = ~w_lane[1];
            w_dq_oe  = 1'b1;
            w_dq_out = w_is_hi ? w_wdata_nxt[31:16] : w_wdata_nxt[15:0];
         end else begin
            w_oe_n = 1'b0;
            w_lb_n = 1'b0;
            w_ub_n = 1'b0;
         end
      end
   end

   // Request payload, read data and registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_word      <= '0;
         r_wren      <= 1'b0;
         r_bmask     <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_ack       <= 1'b0;
         r_busy      <= 1'b0;
         r_sram_addr <= '0;
         r_ce_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_lb_n      <= 1'b1;
         r_ub_n      <= 1'b1;
         r_dq_oe     <= 1'b0;
         r_dq_out    <= '0;
      end else begin
         r_word      <= w_word_nxt;
         r_wren      <= w_wren_nxt;
         r_bmask     <= w_bmask_nxt;
         r_wdata     <= w_wdata_nxt;
         if (w_cap_lo) r_rdata[15:0]  <= SRAM_DQ;
         if (w_cap_hi) r_rdata[31:16] <= SRAM_DQ;
         r_ack       <= (w_state_nxt == ST_ACK);
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_sram_addr <= w_sram_addr;
         r_ce_n      <= w_ce_n;
         r_we_n      <= w_we_n;
         r_oe_n      <= w_oe_n;
         r_lb_n      <= w_lb_n;
         r_ub_n      <= w_ub_n;
         r_dq_oe     <= w_dq_oe;
         r_dq_out    <= w_dq_out;
      end
   end

   assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'hzzzz;
   assign o_rdata   = r_rdata;
   assign o_ack     = r_ack;
   assign o_busy    = r_busy;
   assign SRAM_ADDR = r_sram_addr;
   assign SRAM_CE_N = r_ce_n;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_OE_N = r_oe_n;
   assign SRAM_LB_N = r_lb_n;
   assign SRAM_UB_N = r_ub_n;

endmodule
